// File: rtl/antmicro_ddr5_tester_usp.sv
// DDR5 tester board bring-up sequencer: powers the rails in order, releases
// DRAM reset with the DRAM clock running, prints "OK\n" on the UART and
// raises finish. Losing power-good after the DRAM is powered parks the
// board in FAULT. Command bus, data bus, Ethernet and I2C are held idle.
// dbg_state exposes the sequencer state for checkers.
module antmicro_ddr5_tester_usp #(
  parameter int VIN_DELAY    = 16,
  parameter int RESET_CYCLES = 32,
  parameter int INIT_CYCLES  = 64,
  parameter int UART_DIV     = 8,
  parameter int HB_BIT       = 4
) (
  input  logic        clk100_p,
  input  logic        clk100_n,
  input  logic        sys_rst,
  output logic        serial_tx,
  input  logic        serial_rx,
  output logic        user_led0,
  output logic        user_led1,
  output logic        user_led2,
  output logic        user_led3,
  output logic        user_led4,
  output logic        finish,
  output logic        vin_bulk_en,
  output logic        vin_mgmt_en,
  input  logic        ddr5_pgood,
  input  logic        ddr5_alert_n,
  output logic        ddr5_reset_n,
  output logic        ddr5_ck_t,
  output logic        ddr5_ck_c,
  output logic [6:0]  ddr5_A_ca,
  output logic [6:0]  ddr5_B_ca,
  output logic [1:0]  ddr5_A_cs_n,
  output logic [1:0]  ddr5_B_cs_n,
  output logic        ddr5_A_par,
  output logic        ddr5_B_par,
  inout  wire  [31:0] ddr5_A_dq,
  inout  wire  [31:0] ddr5_B_dq,
  inout  wire  [7:0]  ddr5_A_dqs_t,
  inout  wire  [7:0]  ddr5_A_dqs_c,
  inout  wire  [7:0]  ddr5_B_dqs_t,
  inout  wire  [7:0]  ddr5_B_dqs_c,
  input  logic [7:0]  ddr5_A_cb,
  input  logic [7:0]  ddr5_B_cb,
  input  logic [1:0]  ddr5_A_dqsb_t,
  input  logic [1:0]  ddr5_A_dqsb_c,
  input  logic [1:0]  ddr5_B_dqsb_t,
  input  logic [1:0]  ddr5_B_dqsb_c,
  input  logic        ddr5_dlbdq,
  input  logic        ddr5_dlbdqs,
  input  logic        eth_clocks_rx,
  input  logic        eth_rx_ctl,
  input  logic [3:0]  eth_rx_data,
  output logic        eth_clocks_tx,
  output logic        eth_rst_n,
  output logic        eth_mdc,
  output logic        eth_tx_ctl,
  output logic [3:0]  eth_tx_data,
  inout  wire         eth_mdio,
  inout  wire         i2c_sda,
  inout  wire         i2c_scl,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_OFF, S_MGMT, S_BULK, S_DRST, S_INIT, S_BANNER, S_DONE, S_FAULT
  } state_t;

  // Terminal counts: each timed state lasts exactly N cycles.
  localparam logic [15:0] VIN_LAST  = 16'(VIN_DELAY - 1);
  localparam logic [15:0] RST_LAST  = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] DIV_LAST  = 16'(UART_DIV - 1);

  logic        clk;
  logic        rst;
  state_t      state, next_state;
  logic [15:0] cnt;
  logic [15:0] div_cnt;
  logic [3:0]  bit_pos;   // 0 start, 1..8 data LSB first, 9 stop
  logic [1:0]  byte_idx;
  logic [7:0]  cur_byte;
  logic [3:0]  data_idx;
  logic        uart_bit;
  logic        uart_last;
  logic        clk_run_next;
  logic [31:0] hb;
  logic        alert_seen;
  logic        unused_inputs;

  assign clk       = clk100_p;
  assign rst       = sys_rst;
  assign dbg_state = state;

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OFF;
    else     state <= next_state;
  end

  // Next-state logic; power-good loss wins over any timed transition.
  always_comb begin
    next_state = state;
    case (state)
      S_OFF:    next_state = S_MGMT;
      S_MGMT:   if (cnt == VIN_LAST) next_state = S_BULK;
      S_BULK:   if (ddr5_pgood) next_state = S_DRST;
      S_DRST:   if (!ddr5_pgood) next_state = S_FAULT;
                else if (cnt == RST_LAST) next_state = S_INIT;
      S_INIT:   if (!ddr5_pgood) next_state = S_FAULT;
                else if (cnt == INIT_LAST) next_state = S_BANNER;
      S_BANNER: if (!ddr5_pgood) next_state = S_FAULT;
                else if (uart_last) next_state = S_DONE;
      S_DONE:   if (!ddr5_pgood) next_state = S_FAULT;
      default:  next_state = S_FAULT;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    vin_mgmt_en  = 1'b0;
    vin_bulk_en  = 1'b0;
    ddr5_reset_n = 1'b0;
    finish       = 1'b0;
    user_led1    = 1'b0;
    user_led4    = 1'b0;
    serial_tx    = 1'b1;
    case (state)
      S_MGMT: vin_mgmt_en = 1'b1;
      S_BULK, S_DRST: begin
        vin_mgmt_en = 1'b1;
        vin_bulk_en = 1'b1;
      end
      S_INIT: begin
        vin_mgmt_en  = 1'b1;
        vin_bulk_en  = 1'b1;
        ddr5_reset_n = 1'b1;
      end
      S_BANNER: begin
        vin_mgmt_en  = 1'b1;
        vin_bulk_en  = 1'b1;
        ddr5_reset_n = 1'b1;
        serial_tx    = uart_bit;
      end
      S_DONE: begin
        vin_mgmt_en  = 1'b1;
        vin_bulk_en  = 1'b1;
        ddr5_reset_n = 1'b1;
        finish       = 1'b1;
        user_led1    = 1'b1;
      end
      S_FAULT: begin
        finish    = 1'b1;
        user_led4 = 1'b1;
      end
      default: ;
    endcase
  end

  // Per-state cycle counter, cleared on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          cnt <= '0;
    else if (next_state != state)                     cnt <= '0;
    else if (state inside {S_MGMT, S_DRST, S_INIT})   cnt <= cnt + 16'd1;
  end

  // UART bit timing: divider, bit position within frame, byte within banner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      bit_pos  <= '0;
      byte_idx <= '0;
    end else if (state != S_BANNER) begin
      div_cnt  <= '0;
      bit_pos  <= '0;
      byte_idx <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      if (bit_pos == 4'd9) begin
        bit_pos  <= '0;
        byte_idx <= byte_idx + 2'd1;
      end else begin
        bit_pos <= bit_pos + 4'd1;
      end
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // Banner character and serial bit for the current frame position.
  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = 8'h4F;
      2'd1:    cur_byte = 8'h4B;
      default: cur_byte = 8'h0A;
    endcase
    data_idx = bit_pos - 4'd1;
    if (bit_pos == 4'd0)      uart_bit = 1'b0;
    else if (bit_pos == 4'd9) uart_bit = 1'b1;
    else                      uart_bit = cur_byte[data_idx[2:0]];
  end

  assign uart_last = (byte_idx == 2'd2) && (bit_pos == 4'd9) && (div_cnt == DIV_LAST);

  // The DRAM clock runs in every state where the DRAM is powered and sane;
  // looking at next_state stops it on the same edge that enters FAULT.
  assign clk_run_next = next_state inside {S_DRST, S_INIT, S_BANNER, S_DONE};

  // DRAM clock divider: clk/2 while running, parked low otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               ddr5_ck_t <= 1'b0;
    else if (clk_run_next) ddr5_ck_t <= ~ddr5_ck_t;
    else                   ddr5_ck_t <= 1'b0;
  end

  assign ddr5_ck_c = ~ddr5_ck_t;

  // Free-running heartbeat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hb <= '0;
    else     hb <= hb + 32'd1;
  end

  // Sticky DRAM alert, only recorded once the board reached DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   alert_seen <= 1'b0;
    else if (state == S_DONE && !ddr5_alert_n) alert_seen <= 1'b1;
  end

  assign user_led0 = hb[HB_BIT];
  assign user_led2 = ddr5_pgood;
  assign user_led3 = alert_seen;

  // Idle command bus on both channels, data strobes and data released.
  assign ddr5_A_ca    = '0;
  assign ddr5_B_ca    = '0;
  assign ddr5_A_cs_n  = 2'b11;
  assign ddr5_B_cs_n  = 2'b11;
  assign ddr5_A_par   = 1'b0;
  assign ddr5_B_par   = 1'b0;
  assign ddr5_A_dq    = 'z;
  assign ddr5_B_dq    = 'z;
  assign ddr5_A_dqs_t = 'z;
  assign ddr5_A_dqs_c = 'z;
  assign ddr5_B_dqs_t = 'z;
  assign ddr5_B_dqs_c = 'z;

  // Ethernet PHY held in reset, management and I2C buses released.
  assign eth_clocks_tx = 1'b0;
  assign eth_rst_n     = 1'b0;
  assign eth_mdc       = 1'b0;
  assign eth_tx_ctl    = 1'b0;
  assign eth_tx_data   = '0;
  assign eth_mdio      = 1'bz;
  assign i2c_sda       = 1'bz;
  assign i2c_scl       = 1'bz;

  assign unused_inputs = ^{clk100_n, serial_rx, ddr5_A_cb, ddr5_B_cb,
                           ddr5_A_dqsb_t, ddr5_A_dqsb_c, ddr5_B_dqsb_t, ddr5_B_dqsb_c,
                           ddr5_dlbdq, ddr5_dlbdqs, eth_clocks_rx, eth_rx_ctl,
                           eth_rx_data, hb};

endmodule

// File: tb/tb_antmicro_ddr5_tester_usp.sv
// Bench for the DDR5 tester sequencer: timing of the power-up sequence,
// UART banner decode through a scoreboard, fault and reset behaviour.
module tb_antmicro_ddr5_tester_usp;

  localparam int VIN_DELAY     = 16;
  localparam int RESET_CYCLES  = 32;
  localparam int INIT_CYCLES   = 64;
  localparam int UART_DIV      = 8;
  localparam int HB_BIT        = 4;
  localparam int BANNER_CYCLES = 3 * 10 * UART_DIV;

  // ---------------- clock / reset ----------------
  logic clk;
  logic sys_rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DUT signals
  logic        serial_tx, serial_rx;
  logic        user_led0, user_led1, user_led2, user_led3, user_led4, finish;
  logic        vin_bulk_en, vin_mgmt_en, ddr5_pgood, ddr5_alert_n, ddr5_reset_n;
  logic        ddr5_ck_t, ddr5_ck_c;
  logic [6:0]  ddr5_A_ca, ddr5_B_ca;
  logic [1:0]  ddr5_A_cs_n, ddr5_B_cs_n;
  logic        ddr5_A_par, ddr5_B_par;
  wire  [31:0] ddr5_A_dq, ddr5_B_dq;
  wire  [7:0]  ddr5_A_dqs_t, ddr5_A_dqs_c, ddr5_B_dqs_t, ddr5_B_dqs_c;
  logic [7:0]  ddr5_A_cb, ddr5_B_cb;
  logic [1:0]  ddr5_A_dqsb_t, ddr5_A_dqsb_c, ddr5_B_dqsb_t, ddr5_B_dqsb_c;
  logic        ddr5_dlbdq, ddr5_dlbdqs;
  logic        eth_clocks_rx, eth_rx_ctl;
  logic [3:0]  eth_rx_data;
  logic        eth_clocks_tx, eth_rst_n, eth_mdc, eth_tx_ctl;
  logic [3:0]  eth_tx_data;
  wire         eth_mdio, i2c_sda, i2c_scl;
  logic [2:0]  dbg_state;

  antmicro_ddr5_tester_usp #(
    .VIN_DELAY(VIN_DELAY), .RESET_CYCLES(RESET_CYCLES), .INIT_CYCLES(INIT_CYCLES),
    .UART_DIV(UART_DIV), .HB_BIT(HB_BIT)
  ) dut (
    .clk100_p(clk), .clk100_n(~clk), .sys_rst(sys_rst),
    .serial_tx(serial_tx), .serial_rx(serial_rx),
    .user_led0(user_led0), .user_led1(user_led1), .user_led2(user_led2),
    .user_led3(user_led3), .user_led4(user_led4), .finish(finish),
    .vin_bulk_en(vin_bulk_en), .vin_mgmt_en(vin_mgmt_en),
    .ddr5_pgood(ddr5_pgood), .ddr5_alert_n(ddr5_alert_n), .ddr5_reset_n(ddr5_reset_n),
    .ddr5_ck_t(ddr5_ck_t), .ddr5_ck_c(ddr5_ck_c),
    .ddr5_A_ca(ddr5_A_ca), .ddr5_B_ca(ddr5_B_ca),
    .ddr5_A_cs_n(ddr5_A_cs_n), .ddr5_B_cs_n(ddr5_B_cs_n),
    .ddr5_A_par(ddr5_A_par), .ddr5_B_par(ddr5_B_par),
    .ddr5_A_dq(ddr5_A_dq), .ddr5_B_dq(ddr5_B_dq),
    .ddr5_A_dqs_t(ddr5_A_dqs_t), .ddr5_A_dqs_c(ddr5_A_dqs_c),
    .ddr5_B_dqs_t(ddr5_B_dqs_t), .ddr5_B_dqs_c(ddr5_B_dqs_c),
    .ddr5_A_cb(ddr5_A_cb), .ddr5_B_cb(ddr5_B_cb),
    .ddr5_A_dqsb_t(ddr5_A_dqsb_t), .ddr5_A_dqsb_c(ddr5_A_dqsb_c),
    .ddr5_B_dqsb_t(ddr5_B_dqsb_t), .ddr5_B_dqsb_c(ddr5_B_dqsb_c),
    .ddr5_dlbdq(ddr5_dlbdq), .ddr5_dlbdqs(ddr5_dlbdqs),
    .eth_clocks_rx(eth_clocks_rx), .eth_rx_ctl(eth_rx_ctl), .eth_rx_data(eth_rx_data),
    .eth_clocks_tx(eth_clocks_tx), .eth_rst_n(eth_rst_n), .eth_mdc(eth_mdc),
    .eth_tx_ctl(eth_tx_ctl), .eth_tx_data(eth_tx_data),
    .eth_mdio(eth_mdio), .i2c_sda(i2c_sda), .i2c_scl(i2c_scl),
    .dbg_state(dbg_state)
  );

  // Cycles elapsed since reset release (sampled on the falling edge).
  int cyc;
  always @(posedge clk or posedge sys_rst) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  bit         mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART monitor: decodes 8N1 frames mid-bit and pops the expected byte.
  logic [7:0] mon_data;
  logic       mon_start, mon_stop;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !sys_rst && serial_tx === 1'b0) begin
        repeat (UART_DIV / 2) @(negedge clk);
        mon_start = serial_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (UART_DIV) @(negedge clk);
          mon_data[i] = serial_tx;
        end
        repeat (UART_DIV) @(negedge clk);
        mon_stop = serial_tx;
        check("uart_start_bit", mon_start, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL uart_unexpected_byte: got 0x%0h expected none", mon_data);
        end else begin
          check("uart_byte", mon_data, exp_q.pop_front());
        end
        check("uart_stop_bit", mon_stop, 1'b1);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  function automatic logic sig_sel(input int which);
    case (which)
      0:       return vin_mgmt_en;
      1:       return vin_bulk_en;
      2:       return ddr5_ck_t;
      3:       return ddr5_reset_n;
      default: return finish;
    endcase
  endfunction

  task automatic wait_rise(input int which, input string name, output int stamp);
    int n;
    n = 0;
    while (sig_sel(which) !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sig_sel(which) !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s: got no rise after %0d cycles expected rise", name, n);
    end
    stamp = cyc;
  endtask

  task automatic check_reset_state();
    check("rst_mgmt_en", vin_mgmt_en, 1'b0);
    check("rst_bulk_en", vin_bulk_en, 1'b0);
    check("rst_reset_n", ddr5_reset_n, 1'b0);
    check("rst_ck_t", ddr5_ck_t, 1'b0);
    check("rst_ck_c", ddr5_ck_c, 1'b1);
    check("rst_finish", finish, 1'b0);
    check("rst_serial_tx", serial_tx, 1'b1);
    check("rst_leds_0_1_3_4", {user_led0, user_led1, user_led3, user_led4}, 4'b0000);
    check("rst_led2_pgood", user_led2, ddr5_pgood);
    check("rst_cs_n", {ddr5_A_cs_n, ddr5_B_cs_n}, 4'b1111);
    check("rst_ca_par", {ddr5_A_ca, ddr5_B_ca, ddr5_A_par, ddr5_B_par}, 16'h0);
    check("rst_eth", {eth_clocks_tx, eth_rst_n, eth_mdc, eth_tx_ctl, eth_tx_data}, 8'h0);
  endtask

  // Reset, power the rails and bring the DRAM out of reset; returns the
  // cycle stamp at which ddr5_reset_n went high.
  task automatic start_sequence(input int pg_delay, output int t_rstn);
    int t_mgmt, t_bulk, t_pg, t_drst, errs;
    logic prev;
    sys_rst = 1'b1;
    ddr5_pgood = 1'b0;
    ddr5_alert_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state();
    sys_rst = 1'b0;
    wait_rise(0, "mgmt", t_mgmt);
    check("mgmt_rise_cycle", t_mgmt, 1);
    check("bulk_low_in_mgmt", vin_bulk_en, 1'b0);
    wait_rise(1, "bulk", t_bulk);
    check("bulk_after_mgmt", t_bulk - t_mgmt, VIN_DELAY);
    // alert outside DONE must not be latched
    ddr5_alert_n = 1'b0;
    @(negedge clk);
    ddr5_alert_n = 1'b1;
    repeat (pg_delay) @(negedge clk);
    check("bulk_wait_reset_n", ddr5_reset_n, 1'b0);
    check("bulk_wait_ck", ddr5_ck_t, 1'b0);
    ddr5_pgood = 1'b1;
    t_pg = cyc;
    wait_rise(2, "ck", t_drst);
    check("drst_entry", t_drst - t_pg, 1);
    errs = 0;
    prev = ddr5_ck_t;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ddr5_ck_t === prev || ddr5_ck_c !== ~ddr5_ck_t) errs++;
      prev = ddr5_ck_t;
    end
    check("ck_toggle_errs", errs, 0);
    check("reset_n_low_in_drst", ddr5_reset_n, 1'b0);
    wait_rise(3, "reset_n", t_rstn);
    check("reset_n_after_drst", t_rstn - t_drst, RESET_CYCLES);
  endtask

  task automatic run_normal(input int pg_delay);
    int t_rstn, t_fin, errs;
    exp_q.push_back(8'h4F);
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'h0A);
    mon_en = 1'b1;
    start_sequence(pg_delay, t_rstn);
    wait_rise(4, "finish", t_fin);
    check("finish_after_init", t_fin - t_rstn, INIT_CYCLES + BANNER_CYCLES);
    check("done_led1", user_led1, 1'b1);
    check("done_led4", user_led4, 1'b0);
    check("done_led3_clear", user_led3, 1'b0);
    check("done_rails", {vin_mgmt_en, vin_bulk_en, ddr5_reset_n}, 3'b111);
    check("done_serial_idle", serial_tx, 1'b1);
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (user_led0 !== 1'((cyc >> HB_BIT) & 1)) errs++;
      if (ddr5_ck_c !== ~ddr5_ck_t) errs++;
    end
    check("heartbeat_errs", errs, 0);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    ddr5_alert_n = 1'b0;
    @(negedge clk);
    ddr5_alert_n = 1'b1;
    repeat ($urandom_range(2, 40)) @(negedge clk);
    check("alert_sticky", user_led3, 1'b1);
    check("done_terminal", finish, 1'b1);
    sys_rst = 1'b1;
    #1;
    check("alert_cleared_by_reset", user_led3, 1'b0);
    check("finish_cleared_by_reset", finish, 1'b0);
    mon_en = 1'b0;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int t, k, errs;
    logic [2:0] st;
    sys_rst = 1'b1;
    ddr5_pgood = 1'b0;
    ddr5_alert_n = 1'b1;
    serial_rx = 1'b1;
    ddr5_A_cb = '0; ddr5_B_cb = '0;
    ddr5_A_dqsb_t = '0; ddr5_A_dqsb_c = '0; ddr5_B_dqsb_t = '0; ddr5_B_dqsb_c = '0;
    ddr5_dlbdq = 1'b0; ddr5_dlbdqs = 1'b0;
    eth_clocks_rx = 1'b0; eth_rx_ctl = 1'b0; eth_rx_data = '0;
    repeat (4) @(negedge clk);
    check_reset_state();
    ddr5_pgood = 1'b1;
    #1;
    check("led2_tracks_pgood_hi", user_led2, 1'b1);
    ddr5_pgood = 1'b0;
    #1;
    check("led2_tracks_pgood_lo", user_led2, 1'b0);

    // power-good never arrives: sequencer parks in BULK
    @(negedge clk);
    sys_rst = 1'b0;
    wait_rise(1, "bulk_hold", t);
    st = dbg_state;
    errs = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (finish || ddr5_ck_t || !ddr5_ck_c || !vin_bulk_en || ddr5_reset_n ||
          user_led4 || dbg_state !== st) errs++;
    end
    check("pgood_low_hold_errs", errs, 0);
    check("pgood_low_finish", finish, 1'b0);

    // power-good lost during INIT
    start_sequence($urandom_range(0, 5), t);
    k = $urandom_range(0, INIT_CYCLES - 4);
    repeat (k) @(negedge clk);
    ddr5_pgood = 1'b0;
    @(negedge clk);
    check("fault_rails", {vin_mgmt_en, vin_bulk_en, ddr5_reset_n}, 3'b000);
    check("fault_led4", user_led4, 1'b1);
    check("fault_finish", finish, 1'b1);
    check("fault_ck", {ddr5_ck_t, ddr5_ck_c}, 2'b01);
    check("fault_serial_tx", serial_tx, 1'b1);
    check("fault_led1", user_led1, 1'b0);
    ddr5_pgood = 1'b1;
    repeat (20) @(negedge clk);
    check("fault_terminal", {user_led4, vin_mgmt_en, ddr5_ck_t}, 3'b100);

    // reset asserted asynchronously in the middle of the banner
    mon_en = 1'b0;
    start_sequence($urandom_range(0, 10), t);
    repeat (INIT_CYCLES + $urandom_range(8, BANNER_CYCLES - 8)) @(negedge clk);
    check("mid_banner_not_done", finish, 1'b0);
    @(posedge clk);
    #2;
    sys_rst = 1'b1;
    #1;
    check_reset_state();

    // full sequences with random power-good latency
    run_normal($urandom_range(0, 20));
    run_normal($urandom_range(21, 80));
    repeat (UART_DIV * 2) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
